// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the memory stage and its data memory.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] NO_REG = 4'hF;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ) || (icode == ICODE_RET);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
  endfunction

  // Pops and returns address memory through the stack pointer carried in valA.
  function automatic logic addr_from_vala(input logic [3:0] icode);
    return (icode == ICODE_POPQ) || (icode == ICODE_RET);
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-addressed data memory: 8-byte little-endian access at any alignment,
// combinational read, posedge write, and a preload port that overrides the pipeline.
module data_mem #(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rd_en,
  input  logic [63:0] rd_addr,
  output logic [63:0] rd_data,
  input  logic        wr_en,
  input  logic        wr_allow,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic        init_we,
  input  logic [63:0] init_addr,
  input  logic [63:0] init_data,
  output logic        error
);

  localparam int          AW   = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

  logic [7:0]    mem [MEM_BYTES];
  logic          rd_err;
  logic          wr_err;
  logic          wr_commit;
  logic          init_ok;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] wr_base;
  logic [AW-1:0] init_base;

  // Full 64-bit unsigned compare so addresses near 2^64 cannot wrap into range.
  assign rd_err    = rd_en && (rd_addr > LAST);
  assign wr_err    = wr_en && (wr_addr > LAST);
  assign error     = rd_err || wr_err;

  assign rd_base   = rd_err ? '0 : rd_addr[AW-1:0];
  assign wr_base   = wr_addr[AW-1:0];
  assign init_base = init_addr[AW-1:0];

  assign init_ok   = init_we && (init_addr <= LAST);
  assign wr_commit = wr_en && wr_allow && !wr_err && !init_we;

  always_comb begin
    rd_data = '0;
    if (rd_en && !rd_err) begin
      for (int i = 0; i < 8; i++) begin
        rd_data[8*i +: 8] = mem[rd_base + AW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init_ok) begin
      for (int i = 0; i < 8; i++) begin
        mem[init_base + AW'(i)] <= init_data[8*i +: 8];
      end
    end else if (wr_commit) begin
      for (int i = 0; i < 8; i++) begin
        mem[wr_base + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86 memory stage: selects the data-memory access for the M-register instruction,
// produces m_stat/m_valM for forwarding, and holds the M->W pipeline register.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_CND,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic        init_we,
  input  logic [63:0] init_addr,
  input  logic [63:0] init_data,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  logic        mem_read;
  logic        mem_write;
  logic        wr_allow;
  logic        dmem_error;
  logic [63:0] mem_addr;
  logic [63:0] rd_data;
  logic        unused_cnd;

  logic [2:0]  w_stat_q,  w_stat_d;
  logic [3:0]  w_icode_q, w_icode_d;
  logic [63:0] w_vale_q,  w_vale_d;
  logic [63:0] w_valm_q,  w_valm_d;
  logic [3:0]  w_dste_q,  w_dste_d;
  logic [3:0]  w_dstm_q,  w_dstm_d;

  assign unused_cnd = M_CND;

  assign mem_read  = is_mem_read(M_icode);
  assign mem_write = is_mem_write(M_icode);
  assign mem_addr  = addr_from_vala(M_icode) ? M_valA : M_valE;
  // rst_n is sampled here so a reset held across an edge suppresses the store.
  assign wr_allow  = rst_n && (M_stat == STAT_AOK);

  data_mem #(.MEM_BYTES(MEM_BYTES)) u_dmem (
    .clk       (clk),
    .rd_en     (mem_read),
    .rd_addr   (mem_addr),
    .rd_data   (rd_data),
    .wr_en     (mem_write),
    .wr_allow  (wr_allow),
    .wr_addr   (mem_addr),
    .wr_data   (M_valA),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .error     (dmem_error)
  );

  assign m_stat = dmem_error ? STAT_ADR : M_stat;
  assign m_valM = rd_data;

  always_comb begin
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_vale_d  = w_vale_q;
    w_valm_d  = w_valm_q;
    w_dste_d  = w_dste_q;
    w_dstm_d  = w_dstm_q;
    if (W_bubble) begin
      w_stat_d  = STAT_AOK;
      w_icode_d = ICODE_NOP;
      w_vale_d  = '0;
      w_valm_d  = '0;
      w_dste_d  = NO_REG;
      w_dstm_d  = NO_REG;
    end else if (!W_stall) begin
      w_stat_d  = m_stat;
      w_icode_d = M_icode;
      w_vale_d  = M_valE;
      w_valm_d  = m_valM;
      w_dste_d  = M_dstE;
      w_dstm_d  = M_dstM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_stat_q  <= STAT_AOK;
      w_icode_q <= ICODE_NOP;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
      w_dste_q  <= NO_REG;
      w_dstm_q  <= NO_REG;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
    end
  end

  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_valE  = w_vale_q;
  assign W_valM  = w_valm_q;
  assign W_dstE  = w_dste_q;
  assign W_dstM  = w_dstm_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: stimulus queues expected values tagged with the
// cycle they are due; a negedge monitor compares whatever is due that cycle.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_CND;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        W_stall, W_bubble;
  logic        init_we;
  logic [63:0] init_addr, init_data;
  logic [2:0]  m_stat;
  logic [63:0] m_valM;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;

  memory_stage #(.MEM_BYTES(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_CND(M_CND),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .m_stat(m_stat), .m_valM(m_valM),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  typedef enum int {K_MSTAT, K_MVALM, K_WSTAT, K_WICODE, K_WVALE, K_WVALM, K_WDSTE, K_WDSTM} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input kind_t k);
    case (k)
      K_MSTAT:  return 64'(m_stat);
      K_MVALM:  return m_valM;
      K_WSTAT:  return 64'(W_stat);
      K_WICODE: return 64'(W_icode);
      K_WVALE:  return W_valE;
      K_WVALM:  return W_valM;
      K_WDSTE:  return 64'(W_dstE);
      default:  return 64'(W_dstM);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        logic [63:0] a;
        a = actual(exp_q[i].kind);
        n_cmp++;
        if (a !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", exp_q[i].name, cyc, a, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input kind_t k, input logic [63:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.kind = k; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
  endtask

  task automatic expect_bubble(input int dly, input string nm);
    expect_at(dly, K_WSTAT,  64'd1,  {nm, ".W_stat"});
    expect_at(dly, K_WICODE, 64'h1,  {nm, ".W_icode"});
    expect_at(dly, K_WVALE,  64'd0,  {nm, ".W_valE"});
    expect_at(dly, K_WVALM,  64'd0,  {nm, ".W_valM"});
    expect_at(dly, K_WDSTE,  64'hF,  {nm, ".W_dstE"});
    expect_at(dly, K_WDSTM,  64'hF,  {nm, ".W_dstM"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; M_CND = 1'b0; W_stall = 1'b0; W_bubble = 1'b0; init_we = 1'b0;
    init_addr = '0; init_data = '0;
    set_m(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);

    step();
    expect_bubble(0, "reset");
    expect_at(0, K_MSTAT, 64'd1, "reset.m_stat");
    expect_at(0, K_MVALM, 64'd0, "reset.m_valM");
    n_cmp++;
    if (W_dstM !== 4'hF) begin
      n_bad++;
      $display("FAIL reset.direct.W_dstM: got %h, expected f", W_dstM);
    end
    preload(64'h40, 64'h1122334455667788);
    step(); preload(64'h100, 64'h0102030405060708);
    step(); preload(64'h108, 64'h1112131415161718);
    step(); preload(64'h7F8, 64'hDEADBEEFCAFEF00D);
    step(); preload(64'h200, 64'h0000000000005555);
    step(); init_we = 1'b0; rst_n = 1'b1;

    step(); set_m(3'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'h3);
    expect_at(0, K_MVALM, 64'h1122334455667788, "mrmovq40.m_valM");
    expect_at(0, K_MSTAT, 64'd1, "mrmovq40.m_stat");
    expect_at(1, K_WVALM, 64'h1122334455667788, "mrmovq40.W_valM");
    expect_at(1, K_WDSTM, 64'h3, "mrmovq40.W_dstM");
    expect_at(1, K_WICODE, 64'h5, "mrmovq40.W_icode");
    expect_at(1, K_WVALE, 64'h40, "mrmovq40.W_valE");
    #1;
    n_cmp++;
    if (m_valM !== 64'h1122334455667788) begin
      n_bad++;
      $display("FAIL mrmovq40.direct.m_valM: got %h", m_valM);
    end

    step(); set_m(3'd1, 4'h4, 64'h103, 64'hA5, 4'hF, 4'hF);
    expect_at(0, K_MVALM, 64'd0, "rmmovq103.m_valM");
    expect_at(0, K_MSTAT, 64'd1, "rmmovq103.m_stat");
    step(); set_m(3'd1, 4'h5, 64'h103, 64'd0, 4'hF, 4'h4);
    expect_at(0, K_MVALM, 64'hA5, "rd103.m_valM");
    expect_at(1, K_WVALM, 64'hA5, "rd103.W_valM");
    step(); set_m(3'd1, 4'h5, 64'h100, 64'd0, 4'hF, 4'h5);
    expect_at(0, K_MVALM, 64'h00000000A5060708, "rd100.m_valM");

    step(); preload(64'h100, 64'h0F0E0D0C0B0A0908);
    expect_at(0, K_MVALM, 64'h00000000A5060708, "rd100_samecyc.m_valM");
    step(); init_we = 1'b0;
    expect_at(0, K_MVALM, 64'h0F0E0D0C0B0A0908, "rd100_after.m_valM");

    step(); set_m(3'd1, 4'hA, 64'h7F9, 64'h99, 4'h4, 4'hF);
    expect_at(0, K_MSTAT, 64'd3, "push7f9.m_stat");
    expect_at(0, K_MVALM, 64'd0, "push7f9.m_valM");
    expect_at(1, K_WSTAT, 64'd3, "push7f9.W_stat");
    #1;
    n_cmp++;
    if (m_stat !== 3'd3) begin
      n_bad++;
      $display("FAIL push7f9.direct.m_stat: got %h", m_stat);
    end
    step(); set_m(3'd1, 4'h5, 64'h7F8, 64'd0, 4'hF, 4'h7);
    expect_at(0, K_MVALM, 64'hDEADBEEFCAFEF00D, "rd7f8.m_valM");
    expect_at(0, K_MSTAT, 64'd1, "rd7f8.m_stat");
    #1;
    n_cmp++;
    if (m_valM !== 64'hDEADBEEFCAFEF00D) begin
      n_bad++;
      $display("FAIL rd7f8.direct.m_valM: got %h", m_valM);
    end

    step(); set_m(3'd4, 4'h4, 64'h40, 64'hFFFF, 4'hF, 4'hF);
    expect_at(0, K_MSTAT, 64'd4, "rmmovq_ins.m_stat");
    step(); set_m(3'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'h3);
    expect_at(0, K_MVALM, 64'h1122334455667788, "after_ins.m_valM");

    step(); set_m(3'd1, 4'h4, 64'h40, 64'h7777, 4'hF, 4'hF);
    preload(64'h48, 64'h0000000000000048);
    step(); init_we = 1'b0;
    set_m(3'd1, 4'hB, 64'h48, 64'h40, 4'h4, 4'h6);
    expect_at(0, K_MVALM, 64'h1122334455667788, "popq_after_preload.m_valM");
    expect_at(1, K_WICODE, 64'hB, "popq.W_icode");
    expect_at(1, K_WDSTE, 64'h4, "popq.W_dstE");
    expect_at(1, K_WVALE, 64'h48, "popq.W_valE");

    step(); W_stall = 1'b1; set_m(3'd1, 4'h5, 64'h7F8, 64'd0, 4'hF, 4'h7);
    expect_at(1, K_WICODE, 64'hB, "stall.W_icode");
    expect_at(1, K_WDSTM, 64'h6, "stall.W_dstM");
    expect_at(1, K_WVALM, 64'h1122334455667788, "stall.W_valM");
    step(); W_stall = 1'b0; W_bubble = 1'b1;
    expect_bubble(1, "bubble");
    step(); W_bubble = 1'b0;
    expect_at(1, K_WICODE, 64'h5, "reload.W_icode");
    expect_at(1, K_WDSTM, 64'h7, "reload.W_dstM");
    step(); W_stall = 1'b1; W_bubble = 1'b1;
    expect_bubble(1, "stall_and_bubble");
    step(); W_stall = 1'b0; W_bubble = 1'b0;
    set_m(3'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'h2);

    step(); set_m(3'd1, 4'h8, 64'h200, 64'h1234, 4'h4, 4'hF);
    #2 rst_n = 1'b0;
    expect_bubble(0, "async_rst");
    step(); rst_n = 1'b1;
    set_m(3'd1, 4'h5, 64'h200, 64'd0, 4'hF, 4'h1);
    expect_at(0, K_MVALM, 64'h0000000000005555, "call_target.m_valM");

    step(); set_m(3'd1, 4'h9, 64'h0, 64'h40, 4'h4, 4'hF);
    expect_at(0, K_MVALM, 64'h1122334455667788, "ret.m_valM");
    step(); set_m(3'd1, 4'h5, 64'hFFFFFFFFFFFFFFFC, 64'd0, 4'hF, 4'h1);
    expect_at(0, K_MSTAT, 64'd3, "wrap.m_stat");
    expect_at(0, K_MVALM, 64'd0, "wrap.m_valM");
    #1;
    n_cmp++;
    if (m_stat !== 3'd3) begin
      n_bad++;
      $display("FAIL wrap.direct.m_stat: got %h", m_stat);
    end
    step(); set_m(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);

    step(); step();
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, expected %h", exp_q[0].name, exp_q[0].val);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Y86 pipeline memory stage plus the M→W pipeline register. It consumes the M-register fields (stat, icode, CND, valE, valA, dstE, dstM) and performs the data-memory read or write for the instruction. It produces m_stat and m_valM combinationally for forwarding and hazard control, and latches the write-back register (W_*) on each rising clock edge. It owns the byte-addressed data memory and provides a preload port for benches and the loader.

## Interface
Parameters:
- MEM_BYTES, 2048, data-memory size in bytes; must be a multiple of 8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- M_stat  in  3  stat from M register.
- M_icode  in  4  icode from M register.
- M_CND  in  1  condition flag; passed through unused.
- M_valE  in  64  ALU result or address.
- M_valA  in  64  store data, or pop/ret address.
- M_dstE  in  4  E destination register (4'hF = none).
- M_dstM  in  4  M destination register (4'hF = none).
- W_stall  in  1  hold the W register.
- W_bubble  in  1  load NOP into the W register.
- init_we  in  1  preload write strobe.
- init_addr  in  64  preload byte address; must be 8-aligned.
- init_data  in  64  preload quadword.
- m_stat  out  3  stage status, combinational.
- m_valM  out  64  read data, combinational (0 when no read).
- W_stat  out  3  registered stat.
- W_icode  out  4  registered icode.
- W_valE  out  64  registered valE.
- W_valM  out  64  registered valM.
- W_dstE  out  4  registered dstE.
- W_dstM  out  4  registered dstM.

## Operation
- Stat codes: AOK=1, HLT=2, ADR=3, INS=4. Icodes follow the standard Y86-64 encoding.
- Reads occur for MRMOVQ(5), POPQ(B) and RET(9). Writes occur for RMMOVQ(4), PUSHQ(A) and CALL(8). All other icodes, including X, make no access.
- Address selection:
  - RMMOVQ, PUSHQ, CALL, MRMOVQ use M_valE.
  - POPQ, RET use M_valA.
- Store data is M_valA in every write case. For CALL, M_valA already holds the return PC.
- Accesses are 8 bytes, little-endian, at any byte alignment.
- dmem_error is raised when an access is active and addr > MEM_BYTES-8. The comparison is unsigned 64-bit, so high addresses do not wrap.
- m_stat = ADR when dmem_error is set; otherwise m_stat = M_stat.
- m_valM is the read data; it is 0 on error or when no read occurs.
- A write is committed at posedge only when all of the following hold: rst_n is high, M_stat is AOK, dmem_error is clear, and init_we is low.
- init_we writes init_data at init_addr on posedge regardless of rst_n. Out-of-range preload addresses are ignored. A preload suppresses any pipeline write in the same cycle.
- Data memory is not cleared by reset.
- W register update priority: reset > W_bubble > W_stall > load.
  - Load: W_stat = m_stat, W_icode = M_icode, W_valE = M_valE, W_valM = m_valM, W_dstE = M_dstE, W_dstM = M_dstM.
  - Bubble: stat AOK, icode NOP(1), valE/valM 0, dstE/dstM 4'hF.
  - Stall: all W fields hold.

## Timing
- Reset value of every W output equals the bubble value: stat 1, icode 1, valE 0, valM 0, dstE F, dstM F.
- Read latency is 0 cycles: m_valM and m_stat are valid in the same cycle as the M inputs.
- Write latency is 1 cycle: a read in the same cycle as a write to the same bytes returns the old data; the next cycle returns the new data.
- Read-to-W latency is 1 cycle.
- W_bubble and W_stall both high in one cycle: bubble wins.
- Reset asserted mid-write: no write occurs, and the W register clears immediately (asynchronous).

## Structure
- y86_pkg holds the ICODE_* and STAT_* constants and NO_REG = 4'hF.
- Sub-module data_mem contains the byte array, the 8-byte little-endian read/write, range check and preload port. It exposes rd_addr, rd_en, rd_data, wr_en, wr_addr, wr_data and error.
- memory_stage contains address/data selection, m_stat, and the W register.

## Test plan
- Preload 0x1122334455667788 at byte 0x40; MRMOVQ with M_valE = 0x40 → m_valM = 0x1122334455667788, W_valM equals it after one edge, W_dstM = M_dstM.
- RMMOVQ with M_valE = 0x103 (unaligned), M_valA = 0xA5 → next-cycle MRMOVQ at 0x103 returns 0xA5; a read at 0x100 in the same cycle as the write returns the prior value.
- PUSHQ at M_valE = 0x7F9 with MEM_BYTES = 2048 → m_stat = 3, no write (verified by a later read at 0x7F8), W_stat = 3.
- RMMOVQ with M_stat = 4 → no memory change, m_stat = 4.
- W_stall and then W_bubble, applied alone and together, → hold; NOP with dst F; bubble wins when both are high.
- rst_n pulled low between edges during a CALL → W outputs at bubble values immediately, and the target word is unchanged.
